// File: rtl/cmp_sequencer.sv
// Job sequencer for the two-port memory compare engine: runs a small table of
// address-range compare jobs in turn and folds their fail flags into one verdict.
module cmp_sequencer #(
  parameter int MAX_MEM_DEPTH = 16,
  parameter int NUM_JOBS      = 4,
  parameter int SEL_W         = 2,
  parameter int TIMEOUT       = 1024,
  localparam int AW           = $clog2(MAX_MEM_DEPTH),
  localparam int JW           = $clog2(NUM_JOBS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_we,
  input  logic [JW-1:0]    i_cfg_idx,
  input  logic [AW-1:0]    i_cfg_start_addr,
  input  logic [AW-1:0]    i_cfg_end_addr,
  input  logic [SEL_W-1:0] i_cfg_sel,
  input  logic [JW:0]      i_num_jobs,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fail,
  output logic             o_err,
  output logic             o_cmp_start,
  output logic [AW-1:0]    o_cmp_start_addr,
  output logic [AW-1:0]    o_cmp_end_addr,
  output logic [SEL_W-1:0] o_cmp_sel,
  input  logic             i_cmp_done,
  input  logic             i_cmp_fail
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FIN} state_t;

  state_t           state;
  logic [JW-1:0]    job_idx;
  logic [JW:0]      num_jobs_reg;
  logic [TW-1:0]    tmo_cnt;
  logic             fail_acc;

  logic [AW-1:0]    tbl_start [NUM_JOBS];
  logic [AW-1:0]    tbl_end   [NUM_JOBS];
  logic [SEL_W-1:0] tbl_sel   [NUM_JOBS];

  logic             cfg_open;
  logic             cfg_range_ok;
  logic             num_ok;
  logic             last_job;
  logic [JW-1:0]    job_nxt;

  assign cfg_open     = i_cfg_we && !o_busy;
  assign cfg_range_ok = (i_cfg_start_addr <= i_cfg_end_addr);
  assign num_ok       = (i_num_jobs != '0) && (i_num_jobs <= (JW+1)'(NUM_JOBS));
  assign last_job     = ({1'b0, job_idx} == (num_jobs_reg - (JW+1)'(1)));
  assign job_nxt      = job_idx + JW'(1);

  // Job table is deliberately not reset so its contents survive a mid-run reset.
  for (genvar gi = 0; gi < NUM_JOBS; gi++) begin : g_tbl
    always_ff @(posedge i_clk) begin
      if (cfg_open && cfg_range_ok && (i_cfg_idx == JW'(gi))) begin
        tbl_start[gi] <= i_cfg_start_addr;
        tbl_end[gi]   <= i_cfg_end_addr;
        tbl_sel[gi]   <= i_cfg_sel;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      job_idx          <= '0;
      num_jobs_reg     <= '0;
      tmo_cnt          <= '0;
      fail_acc         <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_fail           <= 1'b0;
      o_err            <= 1'b0;
      o_cmp_start      <= 1'b0;
      o_cmp_start_addr <= '0;
      o_cmp_end_addr   <= '0;
      o_cmp_sel        <= '0;
    end else begin
      o_cmp_start <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            num_jobs_reg <= i_num_jobs;
            job_idx      <= '0;
            fail_acc     <= 1'b0;
            o_fail       <= 1'b0;
            o_err        <= 1'b0;
            o_busy       <= 1'b1;
            if (num_ok) begin
              state            <= ISSUE;
              o_cmp_start      <= 1'b1;
              o_cmp_start_addr <= tbl_start[0];
              o_cmp_end_addr   <= tbl_end[0];
              o_cmp_sel        <= tbl_sel[0];
            end else begin
              state    <= FIN;
              fail_acc <= 1'b1;
              o_done   <= 1'b1;
              o_fail   <= 1'b1;
              o_err    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (i_cmp_done) begin
            fail_acc <= fail_acc | i_cmp_fail;
            state    <= NEXT;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // Engine hung: count the job as failed but keep running the rest.
            fail_acc <= 1'b1;
            o_err    <= 1'b1;
            state    <= NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        NEXT: begin
          if (last_job) begin
            state  <= FIN;
            o_done <= 1'b1;
            o_fail <= fail_acc;
          end else begin
            job_idx          <= job_nxt;
            state            <= ISSUE;
            o_cmp_start      <= 1'b1;
            o_cmp_start_addr <= tbl_start[job_nxt];
            o_cmp_end_addr   <= tbl_end[job_nxt];
            o_cmp_sel        <= tbl_sel[job_nxt];
          end
        end
        FIN: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // A rejected config write raises the sticky error; it takes priority over a same-cycle start clear.
      if (cfg_open && !cfg_range_ok) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmp_sequencer.sv
// Directed bench for cmp_sequencer: a timeline model built from the job table and
// engine delays is compared against the DUT every cycle of each run.
module tb_cmp_sequencer;

  localparam int TMO = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cfg_we = 1'b0;
  logic [1:0] i_cfg_idx = '0;
  logic [3:0] i_cfg_start_addr = '0;
  logic [3:0] i_cfg_end_addr = '0;
  logic [1:0] i_cfg_sel = '0;
  logic [2:0] i_num_jobs = '0;
  logic       i_start = 1'b0;
  logic       o_busy, o_done, o_fail, o_err, o_cmp_start;
  logic [3:0] o_cmp_start_addr, o_cmp_end_addr;
  logic [1:0] o_cmp_sel;
  logic       i_cmp_done = 1'b0;
  logic       i_cmp_fail = 1'b0;

  cmp_sequencer #(
    .MAX_MEM_DEPTH(16), .NUM_JOBS(4), .SEL_W(2), .TIMEOUT(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx),
    .i_cfg_start_addr(i_cfg_start_addr), .i_cfg_end_addr(i_cfg_end_addr),
    .i_cfg_sel(i_cfg_sel), .i_num_jobs(i_num_jobs), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail), .o_err(o_err),
    .o_cmp_start(o_cmp_start), .o_cmp_start_addr(o_cmp_start_addr),
    .o_cmp_end_addr(o_cmp_end_addr), .o_cmp_sel(o_cmp_sel),
    .i_cmp_done(i_cmp_done), .i_cmp_fail(i_cmp_fail)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Bench copy of the job table and per-job engine behaviour (delay 0 = never done).
  int m_start [4];
  int m_end   [4];
  int m_sel   [4];
  int eng_delay [4];
  int eng_fail  [4];
  int eng_job = 0;

  // Expected timeline, indexed by cycles since the start acceptance edge.
  int e_start [256];
  int e_win   [256];
  int e_as    [256];
  int e_ae    [256];
  int e_sel   [256];
  int e_fin = 0;
  int e_fail = 0;
  int e_err = 0;

  int acc_cyc = 0;
  bit run_active = 1'b0;
  int obs_done_s = -1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic build_model(input int n);
    int s;
    int w;
    for (int k = 0; k < 256; k++) begin
      e_start[k] = 0; e_win[k] = 0; e_as[k] = 0; e_ae[k] = 0; e_sel[k] = 0;
    end
    e_fail = 0;
    e_err = 0;
    if (n < 1 || n > 4) begin
      e_fin = 1; e_fail = 1; e_err = 1;
    end else begin
      s = 1;
      for (int j = 0; j < n; j++) begin
        e_start[s] = 1;
        if (eng_delay[j] == 0) begin
          w = TMO; e_fail = 1; e_err = 1;
        end else begin
          w = eng_delay[j];
          if (eng_fail[j] != 0) e_fail = 1;
        end
        for (int k = s; k <= s + w; k++) begin
          e_win[k] = 1; e_as[k] = m_start[j]; e_ae[k] = m_end[j]; e_sel[k] = m_sel[j];
        end
        s = s + w + 2;
      end
      e_fin = s;
    end
  endtask

  task automatic cfg_write(input int idx, input int sa, input int ea, input int sel, input bit lands);
    @(negedge i_clk);
    i_cfg_we = 1'b1; i_cfg_idx = 2'(idx);
    i_cfg_start_addr = 4'(sa); i_cfg_end_addr = 4'(ea); i_cfg_sel = 2'(sel);
    @(negedge i_clk);
    i_cfg_we = 1'b0;
    if (lands) begin
      m_start[idx] = sa; m_end[idx] = ea; m_sel[idx] = sel;
    end
  endtask

  // Engine delay for a job follows the current engine: end - start + 3 cycles.
  task automatic set_job(input int j, input int fail_flag);
    eng_delay[j] = m_end[j] - m_start[j] + 3;
    eng_fail[j] = fail_flag;
  endtask

  task automatic start_run(input int n);
    build_model(n);
    @(negedge i_clk);
    eng_job = 0;
    i_num_jobs = 3'(n);
    i_start = 1'b1;
    obs_done_s = -1;
    acc_cyc = cyc;
    run_active = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_run(input string nm);
    for (int k = 0; k < 300 && run_active; k++) @(negedge i_clk);
    if (run_active) begin
      run_active = 1'b0;
      chk({nm, "_complete"}, 0, 1);
    end
    $display("run %s: done observed at cycle offset %0d, fail=%0d err=%0d", nm, obs_done_s, o_fail, o_err);
  endtask

  // Compare process: checks every cycle of an active run against the timeline.
  initial begin
    int s;
    forever begin
      @(negedge i_clk);
      if (run_active && i_rst_n) begin
        s = cyc - acc_cyc;
        if (s >= 1 && s <= e_fin) begin
          if (o_done) obs_done_s = s;
          chk("busy", int'(o_busy), 1);
          chk("cmp_start", int'(o_cmp_start), e_start[s]);
          chk("done", int'(o_done), int'(s == e_fin));
          if (e_win[s] != 0) begin
            chk("cmp_start_addr", int'(o_cmp_start_addr), e_as[s]);
            chk("cmp_end_addr", int'(o_cmp_end_addr), e_ae[s]);
            chk("cmp_sel", int'(o_cmp_sel), e_sel[s]);
          end
          if (s == e_fin) begin
            chk("fail", int'(o_fail), e_fail);
            chk("err", int'(o_err), e_err);
          end
        end else if (s > e_fin) begin
          chk("busy_after", int'(o_busy), 0);
          chk("done_after", int'(o_done), 0);
          chk("fail_held", int'(o_fail), e_fail);
          run_active = 1'b0;
        end
      end
    end
  end

  // Engine model: answers each start pulse after that job's delay.
  initial begin
    bit pend = 1'b0;
    int due = 0;
    int pfail = 0;
    forever begin
      @(negedge i_clk);
      i_cmp_done = 1'b0;
      i_cmp_fail = 1'b0;
      if (!i_rst_n) begin
        pend = 1'b0;
      end else begin
        if (o_cmp_start) begin
          if (eng_job < 4 && eng_delay[eng_job] > 0) begin
            pend = 1'b1; due = cyc + eng_delay[eng_job]; pfail = eng_fail[eng_job];
          end
          eng_job++;
        end
        if (pend && cyc == due) begin
          i_cmp_done = 1'b1; i_cmp_fail = 1'(pfail); pend = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_fail", int'(o_fail), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_cmp_start", int'(o_cmp_start), 0);
    chk("rst_addr", int'({o_cmp_start_addr, o_cmp_end_addr}), 0);
    chk("rst_sel", int'(o_cmp_sel), 0);
    i_rst_n = 1'b1;

    cfg_write(0, 0, 3, 0, 1'b1);
    cfg_write(1, 4, 7, 1, 1'b1);
    cfg_write(2, 8, 10, 2, 1'b1);
    cfg_write(3, 12, 15, 3, 1'b1);
    for (int j = 0; j < 4; j++) set_job(j, 0);

    // Two passing jobs: 1 + (1+6+1) + (1+6+1) + 1 = 18.
    start_run(2); wait_run("pass2");
    chk("lat_pass2", obs_done_s + 1, 18);

    // Same jobs, job 0 fails: identical timing, verdict set.
    set_job(0, 1);
    start_run(2); wait_run("fail_job0");
    chk("lat_fail_job0", obs_done_s + 1, 18);
    chk("verdict_fail_job0", int'(o_fail), 1);
    set_job(0, 0);

    // Four jobs, selects 0..3; entry 2 is 3 addresses long: 1+8+8+7+8+1 = 33.
    start_run(4); wait_run("sel4");
    chk("lat_sel4", obs_done_s + 1, 33);

    // Job 0 hangs: (1+16+1) for it, job 1 still runs: 1+18+8+1 = 28.
    eng_delay[0] = 0;
    start_run(2); wait_run("timeout");
    chk("lat_timeout", obs_done_s + 1, 28);
    chk("verdict_timeout_err", int'(o_err), 1);
    set_job(0, 0);

    // Bad range write leaves entry 2 untouched and raises the error.
    cfg_write(2, 9, 2, 1, 1'b0);
    chk("bad_cfg_err", int'(o_err), 1);

    // Run using entry 2; a write and a start while busy must both be ignored.
    start_run(3);
    repeat (3) @(negedge i_clk);
    i_start = 1'b1;
    cfg_write(0, 1, 1, 3, 1'b0);
    i_start = 1'b0;
    wait_run("busy_write");
    chk("busy_write_err", int'(o_err), 0);

    // Entry 0 must still hold its original range.
    start_run(1); wait_run("entry0");
    chk("lat_entry0", obs_done_s + 1, 10);

    // Out-of-range job counts go straight to FIN with fail and err.
    start_run(0); wait_run("njobs0");
    chk("lat_njobs0", obs_done_s + 1, 2);
    start_run(5); wait_run("njobs5");

    // Reset during the WAIT of job 1, then a normal rerun on the retained table.
    start_run(2);
    repeat (10) @(negedge i_clk);
    chk("pre_reset_busy", int'(o_busy), 1);
    run_active = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("reset_busy_now", int'(o_busy), 0);
    chk("reset_cmp_start_now", int'(o_cmp_start), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("reset_no_done", int'(o_done), 0);
      chk("reset_busy_low", int'(o_busy), 0);
    end
    i_rst_n = 1'b1;
    start_run(2); wait_run("after_reset");
    chk("lat_after_reset", obs_done_s + 1, 18);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
